// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues sequential fetches to a
// synchronous imem, buffers PC-tagged instructions and hands them to decode.
`timescale 1ns/1ps
module fetch_queue #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(4)
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]           imem_rdata,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTR_W-1:0]           out_instr,
  output logic [ADDR_W-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  entry_t              fifo_q [DEPTH];
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;
  logic                inflight_q, inflight_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                pop, wr_en, issue;
  logic [CW:0]         credits;

  assign out_valid = (count_q != '0) & ~redirect;
  assign pop       = out_valid & out_ready;
  assign wr_en     = inflight_q & ~redirect;

  // Credit counting: the outstanding request already owns a slot, so a
  // returning response can always be written.
  assign credits = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue   = ~reset & ~redirect & (credits < (CW+1)'(DEPTH));

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign out_instr = fifo_q[rd_ptr_q].instr;
  assign out_pc    = fifo_q[rd_ptr_q].pc;
  assign count     = count_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    wr_ptr_d      = wr_ptr_q + PW'(wr_en);
    count_d       = count_q + CW'(wr_en) - CW'(pop);
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + PC_INC;
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage carries no reset; contents are don't-care while out_valid=0.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_q[wr_ptr_q] <= '{instr: imem_rdata, pc: inflight_pc_q};
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_fetch_queue;
  localparam int ADDR_W = 64;
  localparam int INSTR_W = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [63:0] PC_INC = 64'd4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic imem_req, redirect, out_valid, out_ready;
  logic [ADDR_W-1:0] imem_addr, redirect_pc, out_pc, last_addr;
  logic [INSTR_W-1:0] imem_rdata, out_instr;
  logic [CW-1:0] count;

  int total = 0;
  int bad = 0;

  fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH),
                .RESET_PC(RESET_PC), .PC_INC(PC_INC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .count(count));

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  // Synchronous imem: data for the address presented at the previous edge.
  always @(posedge clk) last_addr <= imem_addr;
  assign imem_rdata = word(last_addr);

  typedef struct packed { logic [31:0] instr; logic [63:0] pc; } ent_t;
  ent_t mq[$];
  logic m_infl;
  logic [63:0] m_infl_pc, m_pc;
  logic e_req, e_pop, e_valid;

  function automatic void model_clear();
    mq.delete();
    m_infl = 1'b0;
    m_infl_pc = '0;
    m_pc = RESET_PC;
  endfunction

  function automatic void exp_calc();
    e_valid = (mq.size() != 0) && !redirect;
    e_pop = e_valid && out_ready;
    e_req = !reset && !redirect &&
            ((int'(mq.size()) + int'(m_infl) - int'(e_pop)) < DEPTH);
  endfunction

  function automatic void model_tick();
    if (redirect) begin
      mq.delete();
      m_infl = 1'b0;
      m_pc = redirect_pc;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (m_infl) mq.push_back(ent_t'{instr: word(m_infl_pc), pc: m_infl_pc});
      m_infl = e_req;
      if (e_req) begin
        m_infl_pc = m_pc;
        m_pc = m_pc + PC_INC;
      end
    end
  endfunction

  task automatic sample();
    @(negedge clk);
    exp_calc();
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    model_clear();
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_start(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sample();
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL %s_req cyc=%0d got=%b exp=1", tag, i, imem_req); end
      total++; if (imem_addr !== 64'(4*i)) begin bad++; $display("FAIL %s_addr cyc=%0d got=%h exp=%h", tag, i, imem_addr, 64'(4*i)); end
      total++; if (out_valid !== (i >= 2)) begin bad++; $display("FAIL %s_valid cyc=%0d got=%b exp=%b", tag, i, out_valid, i >= 2); end
      if (i >= 2) begin
        total++; if (out_pc !== 64'(4*(i-2))) begin bad++; $display("FAIL %s_pc cyc=%0d got=%h exp=%h", tag, i, out_pc, 64'(4*(i-2))); end
        total++; if (out_instr !== word(64'(4*(i-2)))) begin bad++; $display("FAIL %s_instr cyc=%0d got=%h exp=%h", tag, i, out_instr, word(64'(4*(i-2)))); end
      end
      total++; if (count > 1) begin bad++; $display("FAIL %s_count cyc=%0d got=%0d exp<=1", tag, i, count); end
      step();
    end
  endtask

  task automatic test_backpressure();
    int n_req = 0;
    logic [63:0] nxt = 64'h0;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample();
      total++; if (imem_req !== e_req) begin bad++; $display("FAIL bp_req cyc=%0d got=%b exp=%b", i, imem_req, e_req); end
      if (imem_req) n_req++;
      step();
    end
    total++; if (n_req != DEPTH) begin bad++; $display("FAIL bp_nreq got=%0d exp=%0d", n_req, DEPTH); end
    total++; if (count !== CW'(DEPTH)) begin bad++; $display("FAIL bp_full got=%0d exp=%0d", count, DEPTH); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sample();
      if (i == 0) begin
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'd16) begin bad++; $display("FAIL bp_resume got=%b/%h exp=1/10", imem_req, imem_addr); end
      end
      total++; if (out_valid !== e_valid) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", i, out_valid, e_valid); end
      if (out_valid) begin
        total++; if (out_pc !== nxt || out_instr !== word(nxt)) begin bad++; $display("FAIL bp_order cyc=%0d got=%h exp=%h", i, out_pc, nxt); end
        nxt = nxt + 64'd4;
      end
      step();
    end
    total++; if (nxt !== 64'd64) begin bad++; $display("FAIL bp_drained got=%h exp=40", nxt); end
  endtask

  task automatic test_redirect();
    int first_v = -1;
    logic [63:0] nxt = 64'h100;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin sample(); step(); end
    total++; if (count !== CW'(3)) begin bad++; $display("FAIL rd_setup count got=%0d exp=3", count); end
    redirect = 1'b1; redirect_pc = 64'h100; out_ready = 1'b1;
    sample();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rd_valid got=%b exp=0", out_valid); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rd_req got=%b exp=0", imem_req); end
    step();
    redirect = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (i == 0) begin
        total++; if (count !== '0) begin bad++; $display("FAIL rd_flush count got=%0d exp=0", count); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h100) begin bad++; $display("FAIL rd_target got=%b/%h exp=1/100", imem_req, imem_addr); end
      end
      if (out_valid) begin
        if (first_v < 0) first_v = i;
        total++; if (out_pc !== nxt) begin bad++; $display("FAIL rd_pc cyc=%0d got=%h exp=%h", i, out_pc, nxt); end
        nxt = nxt + 64'd4;
      end
      step();
    end
    total++; if (first_v != 2) begin bad++; $display("FAIL rd_latency got=%0d exp=2", first_v); end
  endtask

  task automatic test_model_run(input string tag, input int cycles, input int redir_pct);
    for (int i = 0; i < cycles; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      redirect = ($urandom_range(0, 99) < redir_pct);
      redirect_pc = {$urandom(), $urandom()} & ~64'h3;
      sample();
      total++; if (imem_req !== e_req) begin bad++; $display("FAIL %s_req cyc=%0d got=%b exp=%b", tag, i, imem_req, e_req); end
      if (e_req) begin
        total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL %s_addr cyc=%0d got=%h exp=%h", tag, i, imem_addr, m_pc); end
      end
      total++; if (out_valid !== e_valid) begin bad++; $display("FAIL %s_valid cyc=%0d got=%b exp=%b", tag, i, out_valid, e_valid); end
      if (e_valid) begin
        total++; if ({out_instr, out_pc} !== mq[0]) begin bad++; $display("FAIL %s_head cyc=%0d got=%h/%h exp=%h/%h", tag, i, out_instr, out_pc, mq[0].instr, mq[0].pc); end
      end
      total++; if (count !== CW'(mq.size()) || count > DEPTH) begin bad++; $display("FAIL %s_count cyc=%0d got=%0d exp=%0d", tag, i, count, mq.size()); end
      step();
    end
    redirect = 1'b0;
  endtask

  task automatic test_full_toggle();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin sample(); step(); end
    test_model_run("full", 80, 0);
  endtask

  task automatic test_pc_wrap();
    logic [63:0] base = 64'hFFFF_FFFF_FFFF_FFF8;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin sample(); step(); end
    redirect = 1'b1; redirect_pc = base;
    sample(); step();
    redirect = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (i < 4) begin
        total++; if (imem_addr !== base + 64'(4*i)) begin bad++; $display("FAIL wrap_addr cyc=%0d got=%h exp=%h", i, imem_addr, base + 64'(4*i)); end
      end
      if (i >= 2) begin
        total++; if (out_valid !== 1'b1 || out_pc !== base + 64'(4*(i-2))) begin bad++; $display("FAIL wrap_pc cyc=%0d got=%b/%h exp=1/%h", i, out_valid, out_pc, base + 64'(4*(i-2))); end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin sample(); step(); end
    total++; if (count !== CW'(3)) begin bad++; $display("FAIL mid_setup count got=%0d exp=3", count); end
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL mid_req got=%b exp=0", imem_req); end
    total++; if (count !== '0) begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
    @(posedge clk); #1;
    reset = 1'b0;
    test_start("restart");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_start("start");
    test_backpressure();
    test_redirect();
    test_full_toggle();
    test_pc_wrap();
    do_reset();
    test_model_run("rnd", 200, 8);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
